// File: rtl/osd_regaccess_master.sv
// Register-access master: turns a local read/write request into a DII request packet and
// returns the matching response (read data or error) as a one-cycle ack.
package dii_package;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
endpackage

module osd_regaccess_master
   import dii_package::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TW      = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  id,
   input  logic        req_valid,
   input  logic [9:0]  req_dest,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        ack,
   output logic        err,
   output logic [15:0] rdata,
   output dii_flit     debug_out,
   input  logic        debug_out_ready,
   input  dii_flit     debug_in,
   output logic        debug_in_ready
);

   typedef enum logic [3:0] {
      StIdle, StTxDest, StTxHdr, StTxAddr, StTxWdata,
      StRxDest, StRxHdr, StRxValue, StRxDrop, StRxDropDone, StDone
   } state_e;

   localparam logic [TW-1:0] TimeoutLast = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [9:0]    dest_q, dest_d;
   logic          write_q, write_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          drop_q, drop_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          rx_wait;
   logic          rx_timeout;
   logic          hdr_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         dest_q  <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
      end
   end

   // The response carries its write flag in the same bit position as the request header.
   assign hdr_match  = (debug_in.data[9:0] == dest_q) && (debug_in.data[12] == write_q);
   assign rx_wait    = (state_q == StRxDest) || (state_q == StRxHdr) ||
                       (state_q == StRxValue) || (state_q == StRxDrop);
   assign rx_timeout = (TIMEOUT != 0) && rx_wait && (cnt_q == TimeoutLast);

   always_comb begin
      state_d        = state_q;
      dest_d         = dest_q;
      write_d        = write_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      err_d          = err_q;
      rdata_d        = rdata_q;
      drop_d         = drop_q;
      cnt_d          = cnt_q;
      debug_out      = '0;
      debug_in_ready = 1'b0;

      if (rx_wait) cnt_d = cnt_q + TW'(1);

      unique case (state_q)
         StIdle: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid) drop_d = !debug_in.last;
            if (req_valid && !drop_q) begin
               state_d = StTxDest;
               dest_d  = req_dest;
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end
         end
         StTxDest: begin
            cnt_d           = '0;
            debug_out.valid = 1'b1;
            debug_out.data  = {6'h0, dest_q};
            if (debug_out_ready) state_d = StTxHdr;
         end
         StTxHdr: begin
            cnt_d           = '0;
            debug_out.valid = 1'b1;
            debug_out.data  = {2'b00, 1'b0, write_q, 2'b00, id};
            if (debug_out_ready) state_d = StTxAddr;
         end
         StTxAddr: begin
            cnt_d           = '0;
            debug_out.valid = 1'b1;
            debug_out.last  = !write_q;
            debug_out.data  = addr_q;
            if (debug_out_ready) state_d = write_q ? StTxWdata : StRxDest;
         end
         StTxWdata: begin
            cnt_d           = '0;
            debug_out.valid = 1'b1;
            debug_out.last  = 1'b1;
            debug_out.data  = wdata_q;
            if (debug_out_ready) state_d = StRxDest;
         end
         StRxDest: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid && !debug_in.last) state_d = StRxHdr;
         end
         StRxHdr: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid) begin
               if (!hdr_match) begin
                  state_d = debug_in.last ? StRxDest : StRxDrop;
               end else if (debug_in.data[10]) begin
                  err_d   = 1'b1;
                  state_d = debug_in.last ? StDone : StRxDropDone;
               end else if (write_q) begin
                  err_d   = 1'b0;
                  state_d = StDone;
               end else begin
                  state_d = StRxValue;
               end
            end
         end
         StRxValue: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid) begin
               rdata_d = debug_in.data;
               err_d   = 1'b0;
               state_d = debug_in.last ? StDone : StRxDropDone;
            end
         end
         StRxDrop: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid && debug_in.last) state_d = StRxDest;
         end
         StRxDropDone: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid && debug_in.last) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Timeout wins over any flit taken this cycle; the rest of that packet drains in idle.
      if (rx_timeout) begin
         state_d = StDone;
         err_d   = 1'b1;
         rdata_d = rdata_q;
         drop_d  = debug_in.valid && !debug_in.last;
      end
   end

   assign ack   = (state_q == StDone);
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_osd_regaccess_master.sv
// Scoreboard bench for osd_regaccess_master: stimulus pushes expected flits and completions,
// negedge monitors pop and compare whatever the DUT presents.
module tb_osd_regaccess_master;
   import dii_package::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  id = 10'h001;
   logic        req_valid = 1'b0;
   logic [9:0]  req_dest = 10'h015;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        ack;
   logic        err;
   logic [15:0] rdata;
   dii_flit     debug_out;
   logic        debug_out_ready = 1'b1;
   dii_flit     debug_in = '0;
   logic        debug_in_ready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rx_entry_cyc = 0;
   int rmode = 0;  // 0: ready high, 1: toggle each cycle, 2: driven by stimulus

   logic [16:0] txq[$];  // {last, data}
   logic [16:0] cq[$];   // {err, rdata}
   bit          latq[$]; // completion must land exactly 16 cycles after RX entry

   osd_regaccess_master #(.TIMEOUT(16), .TW(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .id              (id),
      .req_valid       (req_valid),
      .req_dest        (req_dest),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .ack             (ack),
      .err             (err),
      .rdata           (rdata),
      .debug_out       (debug_out),
      .debug_out_ready (debug_out_ready),
      .debug_in        (debug_in),
      .debug_in_ready  (debug_in_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rmode == 0) debug_out_ready = 1'b1;
         else if (rmode == 1) debug_out_ready = ~debug_out_ready;
      end
   end

   // Request-flit monitor
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (!rst && debug_out.valid && debug_out_ready) begin
            if (txq.size() == 0) begin
               chk("unexpected_tx_flit", {15'h0, debug_out.last, debug_out.data}, 32'hFFFF_FFFF);
            end else begin
               e = txq.pop_front();
               chk("tx_flit", {15'h0, debug_out.last, debug_out.data}, {15'h0, e});
               if (debug_out.last) rx_entry_cyc = cyc + 1;
            end
         end
      end
   end

   // Completion monitor
   initial begin
      logic [16:0] e;
      bit          lat;
      forever begin
         @(negedge clk);
         if (!rst && ack) begin
            if (cq.size() == 0) begin
               chk("unexpected_ack", {15'h0, err, rdata}, 32'hFFFF_FFFF);
            end else begin
               e   = cq.pop_front();
               lat = latq.pop_front();
               chk("completion", {15'h0, err, rdata}, {15'h0, e});
               if (lat) chk("timeout_latency", cyc - rx_entry_cyc, 16);
            end
         end
      end
   end

   task automatic issue(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input bit exp_err, input logic [15:0] exp_rdata, input bit lat);
      @(posedge clk);
      #1;
      txq.push_back({1'b0, 16'h0015});
      txq.push_back({1'b0, 3'b000, wr, 12'h001});
      txq.push_back({!wr, addr});
      if (wr) txq.push_back({1'b1, wd});
      cq.push_back({exp_err, exp_rdata});
      latq.push_back(lat);
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_valid = 1'b1;
   endtask

   task automatic wait_tx();
      int n = 0;
      while (txq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (txq.size() != 0) chk("tx_drain_timeout", txq.size(), 0);
   endtask

   task automatic send_flit(input logic [15:0] d, input bit l);
      int n = 0;
      debug_in.valid = 1'b1;
      debug_in.last  = l;
      debug_in.data  = d;
      @(negedge clk);
      while (!debug_in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!debug_in_ready) chk("rx_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      debug_in.valid = 1'b0;
   endtask

   task automatic wait_ack();
      int n = 0;
      @(negedge clk);
      while (!ack && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ack) chk("ack_timeout", 0, 1);
      req_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ack", ack, 0);
      chk("reset_err", err, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_out_valid", debug_out.valid, 0);
      chk("reset_in_ready", debug_in_ready, 1);

      // Plain read
      issue(1'b0, 16'h0000, 16'h0, 1'b0, 16'h1234, 1'b0);
      wait_tx();
      send_flit(16'h0000, 1'b0);
      send_flit(16'h0015, 1'b0);
      send_flit(16'h1234, 1'b1);
      wait_ack();

      // Write under toggling backpressure
      rmode = 1;
      issue(1'b1, 16'h0203, 16'hBEEF, 1'b0, 16'h1234, 1'b0);
      wait_tx();
      rmode = 0;
      send_flit(16'h0001, 1'b0);
      send_flit(16'h1015, 1'b1);
      wait_ack();

      // Slave error, then a normal read
      issue(1'b0, 16'h0010, 16'h0, 1'b1, 16'h1234, 1'b0);
      wait_tx();
      send_flit(16'h0001, 1'b0);
      send_flit(16'h0415, 1'b1);
      wait_ack();
      issue(1'b0, 16'h0011, 16'h0, 1'b0, 16'h5678, 1'b0);
      wait_tx();
      send_flit(16'h0001, 1'b0);
      send_flit(16'h0015, 1'b0);
      send_flit(16'h5678, 1'b1);
      wait_ack();

      // Response from the wrong source is dropped
      issue(1'b0, 16'h0020, 16'h0, 1'b0, 16'h9ABC, 1'b0);
      wait_tx();
      send_flit(16'h0001, 1'b0);
      send_flit(16'h0016, 1'b0);
      send_flit(16'hDEAD, 1'b1);
      send_flit(16'h0001, 1'b0);
      send_flit(16'h0015, 1'b0);
      send_flit(16'h9ABC, 1'b1);
      wait_ack();

      // No response: timeout, then a late packet swallowed in idle
      issue(1'b0, 16'h0030, 16'h0, 1'b1, 16'h9ABC, 1'b1);
      wait_tx();
      wait_ack();
      send_flit(16'h0001, 1'b0);
      send_flit(16'h0015, 1'b0);
      send_flit(16'h1111, 1'b1);
      repeat (10) @(negedge clk);
      chk("late_rsp_rdata", rdata, 16'h9ABC);

      // Reset while the address flit is stalled
      rmode = 2;
      @(posedge clk);
      #1;
      debug_out_ready = 1'b0;
      txq.push_back({1'b0, 16'h0015});
      txq.push_back({1'b0, 16'h0001});
      req_write = 1'b0;
      req_addr  = 16'h0040;
      req_valid = 1'b1;
      debug_out_ready = 1'b1;
      wait_tx();
      @(posedge clk);
      #1;
      debug_out_ready = 1'b0;
      @(negedge clk);
      chk("txaddr_valid", debug_out.valid, 1);
      chk("txaddr_data", debug_out.data, 16'h0040);
      rst = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", debug_out.valid, 0);
      chk("rst_in_ready", debug_in_ready, 1);
      chk("rst_ack", ack, 0);
      rst = 1'b0;
      rmode = 0;

      // Recovery after reset
      issue(1'b0, 16'h0001, 16'h0, 1'b0, 16'hCAFE, 1'b0);
      wait_tx();
      send_flit(16'h0001, 1'b0);
      send_flit(16'h0015, 1'b0);
      send_flit(16'hCAFE, 1'b1);
      wait_ack();

      repeat (5) @(negedge clk);
      chk("txq_empty", txq.size(), 0);
      chk("cq_empty", cq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog expired");
   end

endmodule
